glitc_intercom_deser_align: RTL

GLITC_INTERCOM_DESER_ALIGN -- requirements
Module: glitc_intercom_deser_align

---
 rtl/glitc_intercom_pkg.sv | 44 ++++
 rtl/glitc_intercom_pattern_check.sv | 37 +++
 rtl/glitc_intercom_deser_align.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitc_intercom_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : glitc_intercom_pkg
//  Description : Shared definitions for the GLITC intercom deserializer
//                alignment logic. It holds the alignment FSM state encoding,
//                the IDELAY tap width, the maximum tap, and the eye-centre
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package glitc_intercom_pkg;

   // IDELAY tap geometry
   localparam int               c_tap_w    = 5;
   localparam logic [c_tap_w-1:0] c_max_tap = 5'd31;

   // The eye centre is summed one bit wider so first+last cannot overflow
   localparam int               c_center_w = c_tap_w + 1;

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      LOAD        = 4'd1,
      SETTLE      = 4'd2,
      CHECK       = 4'd3,
      NEXT_TAP    = 4'd4,
      CENTER      = 4'd5,
      SLIP        = 4'd6,
      SLIP_SETTLE = 4'd7,
      SLIP_CHECK  = 4'd8,
      NEXT_LANE   = 4'd9,
      FINISH      = 4'd10
   } state_t;

   // Midpoint of the passing-tap run, truncated toward the lower tap
   function automatic logic [c_tap_w-1:0] center_tap(
      input logic [c_tap_w-1:0] first_good,
      input logic [c_tap_w-1:0] last_good
   );
      logic [c_center_w-1:0] sum;
      sum = {1'b0, first_good} + {1'b0, last_good};
      return c_tap_w'(sum >> 1);
   endfunction

endpackage : glitc_intercom_pkg
`default_nettype wire

// File: rtl/glitc_intercom_pattern_check.sv
`default_nettype none
// ============================================================================
//  Module      : glitc_intercom_pattern_check
//  Description : Compares one deserialized nibble against a training word.
//                rot_match is high when the nibble equals any of the four
//                rotations of the pattern (correct sampling phase, arbitrary
//                word alignment). exact_match is high when the nibble equals
//                the pattern with no rotation (word alignment also correct).
//  Ports       : nibble      in  [3:0] lane data
//                pattern     in  [3:0] training word
//                rot_match   out       equals some rotation of pattern
//                exact_match out       equals pattern exactly
//  Revision    : 1.0 - initial release
// ============================================================================
module glitc_intercom_pattern_check (
   input  logic [3:0] nibble,
   input  logic [3:0] pattern,
   output logic       rot_match,
   output logic       exact_match
);

   // Pattern extended by three wrapped bits; each 4-bit window of it is
   // one rotation, so the four windows cover every alignment.
   logic [6:0] w_wrapped;
   logic [3:0] w_hit;

   assign w_wrapped = {pattern[2:0], pattern};

   for (genvar r = 0; r < 4; r++) begin : g_rot
      assign w_hit[r] = (nibble == w_wrapped[r +: 4]);
   end

   assign rot_match   = |w_hit;
   assign exact_match = w_hit[0];

endmodule : glitc_intercom_pattern_check
`default_nettype wire

// File: rtl/glitc_intercom_deser_align.sv
`default_nettype none
// ============================================================================
//  Module      : glitc_intercom_deser_align
//  Description : Sequential per-lane IDELAY eye sweep and ISERDES word
//                alignment. Each lane is swept from tap 0 upward; a tap
//                passes when the lane shows a rotation of TRAIN_PATTERN for
//                MATCH_CYCLES consecutive cycles. The first contiguous run of
//                passing taps is the eye; its centre is loaded, and the lane
//                is then bitslipped until the nibble matches TRAIN_PATTERN
//                exactly (at most three slips).
//  Ports       : sysclk_i    in   clock (dataclk_div2 domain)
//                rst_i       in   asynchronous active-high reset
//                start_i     in   begin alignment (ignored while busy)
//                data_i      in   [4*NBITS] deserialized nibbles
//                load_o      out  [NBITS]   IDELAY load strobe
//                delay_o     out  [5*NBITS] IDELAY tap per lane
//                bitslip_o   out  [NBITS]   ISERDES bitslip pulse
//                busy_o      out  alignment in progress
//                done_o      out  one-cycle completion pulse
//                locked_o    out  [NBITS]   lane aligned
//                err_o       out  sticky: some lane failed
//                eye_width_o out  [6*NBITS] per-lane eye width
//                                 (only with GLITC_INTERCOM_DESER_ALIGN_STATS_EN)
//  Config      : `define GLITC_INTERCOM_DESER_ALIGN_STATS_EN adds eye_width_o
//  Revision    : 1.0 - initial release
// ============================================================================
module glitc_intercom_deser_align
   import glitc_intercom_pkg::*;
#(
   parameter int         NBITS         = 4,
   parameter logic [3:0] TRAIN_PATTERN = 4'b1100,
   parameter int         SETTLE_CYCLES = 16,
   parameter int         MATCH_CYCLES  = 64
) (
   input  logic                   sysclk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [4*NBITS-1:0]     data_i,
   output logic [NBITS-1:0]       load_o,
   output logic [5*NBITS-1:0]     delay_o,
   output logic [NBITS-1:0]       bitslip_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [NBITS-1:0]       locked_o,
`ifdef GLITC_INTERCOM_DESER_ALIGN_STATS_EN
   output logic [6*NBITS-1:0]     eye_width_o,
`endif
   output logic                   err_o
);

   localparam int c_lane_w  = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int c_cnt_max = (SETTLE_CYCLES > MATCH_CYCLES) ? SETTLE_CYCLES : MATCH_CYCLES;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

   localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0]  c_match_last  = c_cnt_w'(MATCH_CYCLES - 1);
   localparam logic [c_lane_w-1:0] c_last_lane   = c_lane_w'(NBITS - 1);

   state_t                          r_state;
   state_t                          w_next;
   logic [c_lane_w-1:0]             r_lane;
   logic [c_lane_w-1:0]             w_lane_nxt;
   logic [c_tap_w-1:0]              r_tap;
   logic [c_tap_w-1:0]              r_first_good;
   logic [c_tap_w-1:0]              r_last_good;
   logic [c_tap_w-1:0]              w_center;
   logic [c_cnt_w-1:0]              r_cnt;
   logic [1:0]                      r_miss;
   logic                            r_have_pass;
   logic                            r_eye_closed;
   logic                            r_centered;
   logic [NBITS-1:0][c_tap_w-1:0]   r_delay;
   logic [NBITS-1:0]                r_locked;
   logic                            r_err;

   logic [3:0]                      w_lane_data [NBITS];
   logic [3:0]                      w_nibble;
   logic                            w_rot_match;
   logic                            w_exact_match;
   logic                            w_sweep_done;

   // ------------------------------------------------------------------------
   // Lane data selection and pattern comparison
   // ------------------------------------------------------------------------
   for (genvar g = 0; g < NBITS; g++) begin : g_lane
      assign w_lane_data[g] = data_i[4*g +: 4];
   end

   assign w_nibble = w_lane_data[r_lane];

   glitc_intercom_pattern_check u_pattern_check (
      .nibble      (w_nibble),
      .pattern     (TRAIN_PATTERN),
      .rot_match   (w_rot_match),
      .exact_match (w_exact_match)
   );

   // The sweep stops at the last tap (no wrap) or once the eye has closed
   assign w_sweep_done = (r_tap == c_max_tap) || r_eye_closed;
   assign w_center     = center_tap(r_first_good, r_last_good);
   assign w_lane_nxt   = r_lane + 1'b1;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and strobes. Strobes decode from the registered state,
   // so load and bitslip are mutually exclusive and one-hot by lane.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next    = r_state;
      load_o    = '0;
      bitslip_o = '0;
      busy_o    = 1'b1;
      done_o    = 1'b0;

      case (r_state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) w_next = LOAD;
         end
         LOAD: begin
            load_o[r_lane] = 1'b1;
            w_next         = SETTLE;
         end
         SETTLE: begin
            // After the centre tap is loaded, settling leads to word alignment
            if (r_cnt == c_settle_last) w_next = r_centered ? SLIP_CHECK : CHECK;
         end
         CHECK: begin
            if (!w_rot_match || (r_cnt == c_match_last)) w_next = NEXT_TAP;
         end
         NEXT_TAP: begin
            w_next = w_sweep_done ? CENTER : LOAD;
         end
         CENTER: begin
            w_next = r_have_pass ? LOAD : NEXT_LANE;
         end
         SLIP: begin
            bitslip_o[r_lane] = 1'b1;
            w_next            = SLIP_SETTLE;
         end
         SLIP_SETTLE: begin
            if (r_cnt == c_settle_last) w_next = SLIP_CHECK;
         end
         SLIP_CHECK: begin
            // Three slips cover every rotation; a fourth miss fails the lane
            if (w_exact_match || (r_miss == 2'd3)) w_next = NEXT_LANE;
            else                                    w_next = SLIP;
         end
         NEXT_LANE: begin
            w_next = (r_lane == c_last_lane) ? FINISH : LOAD;
         end
         FINISH: begin
            busy_o = 1'b0;
            done_o = 1'b1;
            w_next = IDLE;
         end
         default: begin
            busy_o = 1'b0;
            w_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: lane/tap counters, eye tracking, per-lane results.
   // delay_o is updated on the transition into LOAD so that it is already
   // stable during the load strobe cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lane       <= '0;
         r_tap        <= '0;
         r_first_good <= '0;
         r_last_good  <= '0;
         r_cnt        <= '0;
         r_miss       <= '0;
         r_have_pass  <= 1'b0;
         r_eye_closed <= 1'b0;
         r_centered   <= 1'b0;
         r_delay      <= '0;
         r_locked     <= '0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_lane         <= '0;
                  r_tap          <= '0;
                  r_cnt          <= '0;
                  r_miss         <= '0;
                  r_have_pass    <= 1'b0;
                  r_eye_closed   <= 1'b0;
                  r_centered     <= 1'b0;
                  r_locked       <= '0;
                  r_err          <= 1'b0;
                  r_delay[0]     <= '0;
               end
            end
            SETTLE, SLIP_SETTLE: begin
               r_cnt <= (r_cnt == c_settle_last) ? '0 : r_cnt + 1'b1;
            end
            CHECK: begin
               if (!w_rot_match) begin
                  r_cnt <= '0;
                  // The first failure after a pass ends the eye
                  if (r_have_pass) r_eye_closed <= 1'b1;
               end else if (r_cnt == c_match_last) begin
                  r_cnt       <= '0;
                  r_last_good <= r_tap;
                  if (!r_have_pass) begin
                     r_first_good <= r_tap;
                     r_have_pass  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            NEXT_TAP: begin
               if (!w_sweep_done) begin
                  r_tap           <= r_tap + 1'b1;
                  r_delay[r_lane] <= r_tap + 1'b1;
               end
            end
            CENTER: begin
               if (r_have_pass) begin
                  r_tap           <= w_center;
                  r_delay[r_lane] <= w_center;
                  r_centered      <= 1'b1;
                  r_miss          <= '0;
               end else begin
                  r_err <= 1'b1;
               end
            end
            SLIP_CHECK: begin
               if (w_exact_match) begin
                  r_locked[r_lane] <= 1'b1;
               end else if (r_miss == 2'd3) begin
                  r_err <= 1'b1;
               end else begin
                  r_miss <= r_miss + 1'b1;
               end
            end
            NEXT_LANE: begin
               r_cnt        <= '0;
               r_miss       <= '0;
               r_have_pass  <= 1'b0;
               r_eye_closed <= 1'b0;
               r_centered   <= 1'b0;
               if (r_lane != c_last_lane) begin
                  r_lane              <= w_lane_nxt;
                  r_tap               <= '0;
                  r_delay[w_lane_nxt] <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign delay_o  = r_delay;
   assign locked_o = r_locked;
   assign err_o    = r_err;

`ifdef GLITC_INTERCOM_DESER_ALIGN_STATS_EN
   // ------------------------------------------------------------------------
   // Eye width per lane, written when the lane locks; failed lanes keep 0
   // because every start clears the whole vector.
   // ------------------------------------------------------------------------
   logic [NBITS-1:0][5:0] r_eye_width;

   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         r_eye_width <= '0;
      end else if ((r_state == IDLE) && start_i) begin
         r_eye_width <= '0;
      end else if ((r_state == SLIP_CHECK) && w_exact_match) begin
         r_eye_width[r_lane] <= {1'b0, r_last_good} - {1'b0, r_first_good} + 6'd1;
      end
   end

   assign eye_width_o = r_eye_width;
`else
   // Eye-width statistics are not built in this configuration.
`endif

endmodule : glitc_intercom_deser_align
`default_nettype wire
